score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Score-display controller for the PONG scoreboard. Captures two binary player
//  scores, converts each to two BCD digits with a sequential shift-add-3 FSM, and
//  time-multiplexes four digits onto one shared 7-segment decoder input and four
//  active-low digit enables. The decoder output drives the segment pins directly.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit stays lit (>=2)
//  LZ_BLANK     1      1: blank a tens digit equal to 0; 0: always show it
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  score_l     in   7  left player score, binary; sampled on load
//  score_r     in   7  right player score, binary; sampled on load
//  load        in   1  single-cycle strobe requesting a display update
//  busy        out  1  conversion in progress
//  digit_code  out  4  BCD nibble for the shared decoder input (0..9 only)
//  digit_an    out  4  digit enables, active-low, one-hot-low or all ones (blank)
// BEHAVIOUR
//  Reset values: busy=0, digit_code=0, digit_an=4'b1110, digit index=0,
//   refresh counter=0, committed BCD=00/00, pending=0, FSM=IDLE.
//  rst mid-conversion aborts it; the committed BCD returns to 00/00.
//  Saturation: a sampled score >99 is clamped to 99 before conversion.
//  FSM: IDLE -> CONV_L (7 cycles) -> CONV_R (7 cycles) -> COMMIT (1) -> IDLE.
//   - load in IDLE at edge N: scores sampled into a working register at N;
//     busy=1 for cycles N+1..N+15; committed BCD updated at the end of N+15.
//   - CONV_x: each cycle, add 3 to every BCD nibble >=5, then shift the BCD:bin
//     register left by one. After 7 shifts, tens/units are exact (8-bit BCD).
//   - COMMIT: write both digit pairs atomically to the committed registers. The
//     display never shows a mix of old and new digits.
//   - load while busy: set pending (one deep; extra loads merge). Scores are
//     resampled when pending is serviced. From COMMIT with pending=1, go to
//     CONV_L on the next cycle, resample the scores, clear pending, keep busy=1.
//   - load in the same cycle as COMMIT counts as pending.
//  Scan: free-running refresh counter 0..REFRESH_DIV-1, independent of the FSM.
//   On wrap, digit index advances 0->1->2->3->0.
//   Index map: 0=right units, 1=right tens, 2=left units, 3=left tens.
//  Outputs are registered; they reflect the new index on the cycle after the wrap.
//   digit_code = committed nibble for the index.
//   digit_an = ~(1<<index); it is 4'b1111 when LZ_BLANK=1, the index is 1 or 3,
//   and that tens nibble is 0.
//  A commit is visible at the next output register update; the scan phase is
//   not restarted.
// TESTING
//  1. Reset: assert rst 3 cycles -> busy=0, digit_an=1110, digit_code=0; the scan
//     then cycles 1110,1111(blank),1011,1111 every REFRESH_DIV cycles.
//  2. Load score_l=42, score_r=7 -> busy high exactly 15 cycles; scan then shows
//     code 7,(an 1111),2,4 for indices 0..3.
//  3. Saturation: score_l=127, score_r=100 -> all four digits read 9.
//  4. Load during busy: load 12/34, then at busy cycle 5 change the inputs to
//     56/78 and pulse load -> busy stays high 30 cycles; final 56/78; 12/34 is
//     never displayed.
//  5. Reset mid-conversion at busy cycle 8 -> busy=0 next cycle, display 00/00,
//     the FSM returns to IDLE.
//  6. LZ_BLANK=0, score_r=5 -> index 1 gives an=1101, code=0; run with
//     REFRESH_DIV=2 to check the index wrap 3->0.

Source files
------------

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - PONG score capture, shift-add-3 BCD conversion and 4-digit scan
module score_display_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       load,
    output logic       busy,
    output logic [3:0] digit_code,
    output logic [3:0] digit_an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  step;
    logic [14:0] shreg;
    logic [14:0] shifted;
    logic [6:0]  hold_r;
    logic [7:0]  work_l, work_r;
    logic [7:0]  bcd_l, bcd_r;
    logic        pending;
    logic        last_step;
    logic        svc;

    logic [CW-1:0] ref_cnt;
    logic [1:0]    idx, idx_nxt;
    logic          wrap;
    logic [3:0]    nib;
    logic [3:0]    an_val;

    function automatic logic [6:0] clamp99(input logic [6:0] s);
        return (s > 7'd99) ? 7'd99 : s;
    endfunction

    // One double-dabble step on {tens, units, binary}
    function automatic logic [14:0] dd_step(input logic [14:0] r);
        logic [14:0] t;
        t = r;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    assign shifted   = dd_step(shreg);
    assign last_step = (step == 3'd6);
    assign svc       = pending | load;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV_L;
            CONV_L:  if (last_step) state_nxt = CONV_R;
            CONV_R:  if (last_step) state_nxt = COMMIT;
            COMMIT:  state_nxt = svc ? CONV_L : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step    <= 3'd0;
            shreg   <= 15'd0;
            hold_r  <= 7'd0;
            work_l  <= 8'd0;
            work_r  <= 8'd0;
            bcd_l   <= 8'd0;
            bcd_r   <= 8'd0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg  <= {8'd0, clamp99(score_l)};
                        hold_r <= clamp99(score_r);
                        step   <= 3'd0;
                    end
                end
                CONV_L: begin
                    step <= last_step ? 3'd0 : step + 3'd1;
                    if (last_step) begin
                        work_l <= shifted[14:7];
                        shreg  <= {8'd0, hold_r};
                    end else begin
                        shreg <= shifted;
                    end
                end
                CONV_R: begin
                    step <= last_step ? 3'd0 : step + 3'd1;
                    if (last_step) work_r <= shifted[14:7];
                    else           shreg  <= shifted;
                end
                default: begin
                    // A result superseded by a newer load is dropped, never shown
                    if (svc) begin
                        shreg  <= {8'd0, clamp99(score_l)};
                        hold_r <= clamp99(score_r);
                        step   <= 3'd0;
                    end else begin
                        bcd_l <= work_l;
                        bcd_r <= work_r;
                    end
                end
            endcase
            if (state == COMMIT)    pending <= 1'b0;
            else if (busy && load)  pending <= 1'b1;
        end
    end

    assign wrap    = (ref_cnt == CW'(REFRESH_DIV - 1));
    assign idx_nxt = idx + {1'b0, wrap};

    always_comb begin
        nib = 4'd0;
        case (idx_nxt)
            2'd0: nib = bcd_r[3:0];
            2'd1: nib = bcd_r[7:4];
            2'd2: nib = bcd_l[3:0];
            2'd3: nib = bcd_l[7:4];
            default: nib = 4'd0;
        endcase
        an_val = ~(4'b0001 << idx_nxt);
        if (LZ_BLANK && idx_nxt[0] && (nib == 4'd0)) an_val = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt    <= '0;
            idx        <= 2'd0;
            digit_code <= 4'd0;
            digit_an   <= 4'b1110;
        end else begin
            ref_cnt    <= wrap ? '0 : ref_cnt + 1'b1;
            idx        <= idx_nxt;
            digit_code <= nib;
            digit_an   <= an_val;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - scoreboard bench for score_display_ctrl
module tb_score_display_ctrl;
    localparam int DIV_A = 3;
    localparam int DIV_B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [6:0] score_l = 7'd0;
    logic [6:0] score_r = 7'd0;
    logic       busy_a, busy_b;
    logic [3:0] code_a, an_a, code_b, an_b;

    always #5 clk = ~clk;

    score_display_ctrl #(.REFRESH_DIV(DIV_A), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .score_l(score_l), .score_r(score_r), .load(load),
        .busy(busy_a), .digit_code(code_a), .digit_an(an_a));

    score_display_ctrl #(.REFRESH_DIV(DIV_B), .LZ_BLANK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .score_l(score_l), .score_r(score_r), .load(load),
        .busy(busy_b), .digit_code(code_b), .digit_an(an_b));

    int checks = 0;
    int failures = 0;

    int t = 0;
    bit started = 0;
    bit m_reset_edge = 0;
    bit m_busy = 0;
    bit pend = 0;
    int job_end, job_l, job_r;
    int exp_q[$];

    int shown_l = 0, shown_r = 0, next_l = 0, next_r = 0;
    bit next_valid = 0, prev_busy = 0;

    function automatic int clamp(int s);
        return (s > 99) ? 99 : s;
    endfunction

    function automatic int exp_code(int idx, int l, int r);
        case (idx)
            0: return r % 10;
            1: return r / 10;
            2: return l % 10;
            default: return l / 10;
        endcase
    endfunction

    function automatic int exp_an(int idx, int l, int r, bit lz);
        int tens;
        tens = (idx == 1) ? r / 10 : l / 10;
        if (lz && (idx % 2 == 1) && tens == 0) return 15;
        return (~(1 << idx)) & 15;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    // Timeline model: a job started at edge S finishes at edge S+15; loads seen
    // meanwhile restart it at that edge with fresh inputs and drop its result.
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_busy = 0;
            pend = 0;
            exp_q.delete();
            m_reset_edge = 1;
            started = 1;
        end else begin
            m_reset_edge = 0;
            t++;
            if (m_busy) begin
                if (t == job_end) begin
                    if (pend || load) begin
                        job_end = t + 15;
                        job_l = clamp(int'(score_l));
                        job_r = clamp(int'(score_r));
                        pend = 0;
                    end else begin
                        exp_q.push_back(job_l * 100 + job_r);
                        m_busy = 0;
                    end
                end else if (load) begin
                    pend = 1;
                end
            end else if (load) begin
                m_busy = 1;
                job_end = t + 15;
                job_l = clamp(int'(score_l));
                job_r = clamp(int'(score_r));
            end
        end
    end

    // Monitor: pops an expected result each time the DUT finishes a conversion
    always @(negedge clk) begin
        int ia, ib;
        if (started) begin
            if (m_reset_edge) begin
                shown_l = 0; shown_r = 0; next_valid = 0; prev_busy = 0;
            end else if (next_valid) begin
                shown_l = next_l; shown_r = next_r; next_valid = 0;
            end
            check("busy_a", int'(busy_a), int'(m_busy));
            check("busy_b", int'(busy_b), int'(m_busy));
            ia = (t / DIV_A) % 4;
            ib = (t / DIV_B) % 4;
            check("code_a", int'(code_a), exp_code(ia, shown_l, shown_r));
            check("an_a", int'(an_a), exp_an(ia, shown_l, shown_r, 1'b1));
            check("code_b", int'(code_b), exp_code(ib, shown_l, shown_r));
            check("an_b", int'(an_b), exp_an(ib, shown_l, shown_r, 1'b0));
            if (prev_busy && !busy_a && !m_reset_edge) begin
                check("commit_queued", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    int v;
                    v = exp_q.pop_front();
                    next_l = v / 100;
                    next_r = v % 100;
                    next_valid = 1;
                end
            end
            prev_busy = busy_a;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int l, int r);
        score_l = 7'(l);
        score_r = 7'(r);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) break;
            tick();
        end
        check("idle_timeout", int'(busy_a), 0);
    endtask

    task automatic hold();
        repeat (4 * DIV_A * 2 + 2) tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        hold();

        do_load(42, 7);
        wait_idle();
        hold();

        do_load(127, 100);
        wait_idle();
        hold();

        do_load(12, 34);
        repeat (4) tick();
        do_load(56, 78);
        wait_idle();
        hold();

        do_load(33, 66);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold();

        do_load(0, 5);
        wait_idle();
        hold();

        do_load(11, 22);
        repeat (14) tick();
        do_load(88, 9);
        wait_idle();
        hold();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end else begin
                do_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
                repeat ($urandom_range(0, 35)) tick();
            end
        end

        wait_idle();
        hold();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
